fetch_sequencer: RTL and testbench

Sequences the word-addressed instruction memory for the MIPS core: owns the program counter, issues one request at a time over a req/ack handshake, and presents each fetched instruction with its PC to decode through a valid/ready handshake. Branch/jump redirects from execute are applied with priority and squash any in-flight or held fetch. Sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared types and constants for the instruction fetch sequencer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

  // Width of one instruction word.
  localparam int INST_W = 32;

  // Program counter value loaded on reset unless overridden.
  localparam int DEFAULT_RESET_PC = 0;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_DROP  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer_if                                                   |
// | Instruction-memory request/acknowledge bus.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic                        imem_req;
  logic [ADDR_W-1:0]           imem_addr;
  logic                        imem_ack;
  logic [fetch_pkg::INST_W-1:0] imem_rdata;

  // Sequencer side: issues requests, receives data.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: receives requests, returns data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer                                                      |
// | Owns the PC, issues one instruction-memory request at a time and     |
// | hands each fetched word plus its PC to decode. Redirects from        |
// | execute take priority and squash in-flight or held fetches.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                IMEM_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   imem,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst,
  output logic [ADDR_W-1:0]   inst_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                fetch_fault
);

  localparam logic [ADDR_W-1:0] c_imem_depth = ADDR_W'(IMEM_DEPTH);

  // Where a fresh fetch of 'pc' goes: issue it, or park in FAULT when
  // the address lies beyond the populated memory.
  function automatic state_e launch_state(input logic [ADDR_W-1:0] pc);
    return (pc >= c_imem_depth) ? S_FAULT : S_FETCH;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fault_q, fault_d;

  // Next-state, PC, request address and output-holding-register logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (redirect_valid) begin
      // A redirect overrides everything; an outstanding request must
      // still see its ack, so FETCH/DROP without ack park in DROP.
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      case (state_q)
        S_FETCH, S_DROP: state_d = imem.imem_ack ? launch_state(redirect_pc) : S_DROP;
        default:         state_d = launch_state(redirect_pc);
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = launch_state(pc_q);
        S_FETCH: begin
          if (imem.imem_ack) begin
            inst_d       = imem.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 1'b1;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = launch_state(pc_q);
          end
        end
        S_DROP: begin
          // Squashed request completes; its data is simply not captured.
          if (imem.imem_ack) begin
            state_d = launch_state(pc_q);
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end

    // The request address is captured whenever a new FETCH begins and
    // left untouched through DROP so the pending request stays stable.
    if (state_d == S_FETCH) begin
      addr_d = pc_d;
    end
  end

  // Fault flag mirrors residence in FAULT, registered alongside the state.
  always_comb begin
    fault_d = (state_d == S_FAULT);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem.imem_addr = addr_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer                                                   |
// | Scoreboard bench: stimulus queues expected requests/instructions,    |
// | monitors pop and compare as the sequencer presents them.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inst_ready = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_fault;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) imem_bus ();

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit strict = 1'b0;
  int lat = 1;
  int last_len = 0;
  int mem_cnt = 0;
  int mem_len = 0;
  logic              prev_req = 1'b0;
  logic              prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];
  int          acc_cyc[$];

  // Memory image: instruction word stored at word address a.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h8C00_0000 + a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks after 'lat' request cycles, driven shortly after the edge.
  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && imem_bus.imem_req) begin
        mem_cnt++;
        mem_len++;
        if (mem_cnt >= lat) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = word_of(imem_bus.imem_addr);
          last_len = mem_len;
          mem_cnt = 0;
          mem_len = 0;
        end else begin
          imem_bus.imem_ack = 1'b0;
        end
      end else begin
        imem_bus.imem_ack = 1'b0;
        mem_cnt = 0;
        mem_len = 0;
      end
    end
  end

  // Request monitor: new request address vs expectation; address stable while pending.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
      end else begin
        if (imem_bus.imem_req && (!prev_req || prev_ack)) begin
          if (exp_addr_q.size() > 0) check("req_addr", imem_bus.imem_addr, exp_addr_q.pop_front());
          else if (strict) check("unexpected_req", imem_bus.imem_req, 1'b0);
        end else if (imem_bus.imem_req && prev_req && !prev_ack) begin
          check("addr_stable", imem_bus.imem_addr, prev_addr);
        end
        prev_req  = imem_bus.imem_req;
        prev_ack  = imem_bus.imem_ack;
        prev_addr = imem_bus.imem_addr;
      end
    end
  end

  // Decode-side monitor: every accepted instruction vs scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        if (exp_inst_q.size() > 0) begin
          e = exp_inst_q.pop_front();
          check("inst_pc", inst_pc, {32'd0, e[63:32]});
          check("inst", inst, {32'd0, e[31:0]});
          acc_cyc.push_back(cyc);
        end else if (strict) begin
          check("unexpected_inst", inst_valid, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit presented);
    exp_addr_q.push_back(a);
    if (presented) exp_inst_q.push_back({a, word_of(a)});
  endtask

  task automatic begin_test(input int l, input logic rdy);
    strict = 1'b0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = rdy;
    lat = l;
    tick();
    tick();
    exp_addr_q.delete();
    exp_inst_q.delete();
    acc_cyc.delete();
    strict = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_addr_q.size() + exp_inst_q.size()) > 0 && n < max) begin
      tick();
      n++;
    end
    check(name, exp_addr_q.size() + exp_inst_q.size(), 0);
  endtask

  task automatic wait_req(input string name, input logic [31:0] a, input int max);
    int n = 0;
    while (!(imem_bus.imem_req && imem_bus.imem_addr == a) && n < max) begin
      tick();
      n++;
    end
    check(name, imem_bus.imem_req && imem_bus.imem_addr == a, 1'b1);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!inst_valid && n < max) begin
      tick();
      n++;
    end
    check(name, inst_valid, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   imem_bus.imem_req, 1'b0);
    check({tag, "_addr"},  imem_bus.imem_addr, 0);
    check({tag, "_valid"}, inst_valid, 1'b0);
    check({tag, "_inst"},  inst, 0);
    check({tag, "_pc"},    inst_pc, 0);
    check({tag, "_fault"}, fetch_fault, 1'b0);
  endtask

  initial begin
    // Reset state
    begin_test(1, 1'b1);
    check_reset_values("rst");

    // Zero-wait memory, decode always ready
    for (int a = 0; a < 3; a++) expect_fetch(a, 1'b1);
    rst_n = 1'b1;
    wait_drain("t1_drain", 40);
    strict = 1'b0;
    check("t1_acc_count", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 3) begin
      check("t1_gap01", acc_cyc[1] - acc_cyc[0], 2);
      check("t1_gap12", acc_cyc[2] - acc_cyc[1], 2);
    end

    // 3-cycle memory, decode stalls 4 cycles
    begin_test(3, 1'b0);
    expect_fetch(0, 1'b1);
    expect_fetch(1, 1'b1);
    rst_n = 1'b1;
    wait_valid("t2_valid0", 20);
    check("t2_len0", last_len, 3);
    for (int i = 0; i < 4; i++) begin
      check("t2_stall_inst", inst, word_of(0));
      check("t2_stall_pc", inst_pc, 0);
      check("t2_stall_req", imem_bus.imem_req, 1'b0);
      check("t2_stall_valid", inst_valid, 1'b1);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_valid("t2_valid1", 20);
    check("t2_len1", last_len, 3);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_drain("t2_drain", 20);
    strict = 1'b0;

    // Redirect to 7 while request to 2 is outstanding
    begin_test(3, 1'b1);
    expect_fetch(0, 1'b1);
    expect_fetch(1, 1'b1);
    expect_fetch(2, 1'b0);
    expect_fetch(7, 1'b1);
    rst_n = 1'b1;
    wait_req("t3_see2", 2, 60);
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    tick();
    redirect_valid = 1'b0;
    check("t3_drop_addr", imem_bus.imem_addr, 2);
    check("t3_drop_req", imem_bus.imem_req, 1'b1);
    check("t3_drop_valid", inst_valid, 1'b0);
    wait_drain("t3_drain", 60);
    strict = 1'b0;

    // Redirect to 7 coincident with the ack of addr 2
    begin_test(1, 1'b1);
    expect_fetch(0, 1'b1);
    expect_fetch(1, 1'b1);
    expect_fetch(2, 1'b0);
    expect_fetch(7, 1'b1);
    rst_n = 1'b1;
    wait_req("t4_see2", 2, 40);
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    tick();
    redirect_valid = 1'b0;
    check("t4_next_addr", imem_bus.imem_addr, 7);
    check("t4_valid", inst_valid, 1'b0);
    wait_drain("t4_drain", 40);
    strict = 1'b0;

    // Run off the end of memory, then recover by redirect
    begin_test(1, 1'b1);
    for (int a = 29; a < 32; a++) expect_fetch(a, 1'b1);
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd29;
    tick();
    redirect_valid = 1'b0;
    wait_drain("t5_drain", 40);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_fault", fetch_fault, 1'b1);
      check("t5_req", imem_bus.imem_req, 1'b0);
      check("t5_valid", inst_valid, 1'b0);
    end
    expect_fetch(0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    check("t5_fault_clr", fetch_fault, 1'b0);
    wait_drain("t5_resume", 20);
    strict = 1'b0;

    // Asynchronous reset in the middle of the fetch of addr 5
    begin_test(3, 1'b1);
    for (int a = 0; a < 6; a++) expect_fetch(a, a < 5);
    rst_n = 1'b1;
    wait_req("t6_see5", 5, 100);
    tick();
    #2;
    check("t6_mid_req", imem_bus.imem_req, 1'b1);
    check("t6_drained", exp_addr_q.size() + exp_inst_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    tick();
    exp_addr_q.delete();
    exp_inst_q.delete();
    expect_fetch(0, 1'b1);
    strict = 1'b1;
    rst_n = 1'b1;
    wait_drain("t6_restart", 20);
    strict = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
